qtree_result_buf: RTL

QTREE_RESULT_BUF -- requirements
Module: qtree_result_buf

---
 rtl/qtree_result_buf.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/qtree_result_buf.sv
// qtree_result_buf: result FIFO between the qtree match stage and its consumer.
// Lookup results cannot be back-pressured. in_stall_o asks upstream to stop
// issuing new lookups early enough that the results still in flight fit.
//
// Parameters:
//   ADDR_WIDTH    width of the matched address (must be overridden)
//   BYPASS_WIDTH  width of the per-lookup request tag (must be overridden)
//   DEPTH         number of entries, power of 2, >= 4
//   AFULL_MARGIN  free-entry threshold that raises in_stall_o, 1..DEPTH-1
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-low reset
//   lookup_valid_i           a result is present this cycle
//   lookup_match_i           the result carries a match
//   lookup_addr_i            the result address
//   lookup_bypass_i          the result tag
//   in_stall_o               almost full
//   out_valid_o              head entry valid
//   out_ready_i              consumer takes the head entry
//   out_match_o, out_addr_o, out_bypass_o
//                            head entry payload
//   used_o                   number of occupied entries
//   overflow_o               sticky flag, a result was dropped
//   match_cnt_o, miss_cnt_o, drop_cnt_o
//                            32-bit saturating statistics
//
// Build option: define QTREE_RESULT_STATS_EN to build the statistics
// counters. Without it the counter outputs are tied to zero.

module qtree_result_buf #(
    parameter int ADDR_WIDTH   = -1,
    parameter int BYPASS_WIDTH = -1,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    lookup_match_i,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
    input  logic [BYPASS_WIDTH-1:0] lookup_bypass_i,
    input  logic                    lookup_valid_i,
    output logic                    in_stall_o,

    output logic                    out_match_o,
    output logic [ADDR_WIDTH-1:0]   out_addr_o,
    output logic [BYPASS_WIDTH-1:0] out_bypass_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,

    output logic [$clog2(DEPTH):0]  used_o,
    output logic                    overflow_o,

    output logic [31:0]             match_cnt_o,
    output logic [31:0]             miss_cnt_o,
    output logic [31:0]             drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = 1 + ADDR_WIDTH + BYPASS_WIDTH;

    localparam logic [PW:0] LP_FULL  = (PW+1)'(DEPTH);
    localparam logic [PW:0] LP_AFULL = (PW+1)'(DEPTH - AFULL_MARGIN);

    logic [DW-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_used;
    logic          r_ovf;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;

    // Occupancy, not pointer equality, tells full from empty.
    assign w_empty = (r_used == '0);
    assign w_full  = (r_used == LP_FULL);

    // out_ready_i is ignored when there is nothing to pop.
    assign w_pop   = !w_empty && out_ready_i;

    // A push into a full buffer still fits when the head leaves this edge.
    assign w_push  = lookup_valid_i && (!w_full || w_pop);
    assign w_drop  = lookup_valid_i && w_full && !w_pop;

    assign w_wdata = {lookup_match_i, lookup_addr_i, lookup_bypass_i};

    // Payload storage is not reset; it is only read while out_valid_o=1.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_used <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_used <= r_used + (PW+1)'(1);
                2'b01:   r_used <= r_used - (PW+1)'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // Head is read straight from storage: a push into an empty buffer
    // only shows up after the edge that wrote it.
    assign w_rdata = r_mem[r_rptr];

    assign {out_match_o, out_addr_o, out_bypass_o} = w_rdata;

    // Both flags derive from r_used, so reset clears them asynchronously.
    assign out_valid_o = !w_empty;
    assign in_stall_o  = (r_used >= LP_AFULL);
    assign used_o      = r_used;
    assign overflow_o  = r_ovf;

`ifdef QTREE_RESULT_STATS_EN

    logic [31:0] r_match_cnt;
    logic [31:0] r_miss_cnt;
    logic [31:0] r_drop_cnt;

    // All counters saturate rather than wrap.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push && lookup_match_i && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + 32'd1;
            end
            if (w_push && !lookup_match_i && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign match_cnt_o = r_match_cnt;
    assign miss_cnt_o  = r_miss_cnt;
    assign drop_cnt_o  = r_drop_cnt;

`else

    assign match_cnt_o = 32'h0;
    assign miss_cnt_o  = 32'h0;
    assign drop_cnt_o  = 32'h0;

`endif

endmodule
